hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Sequences the operand hazards of the 5-stage interrupt pipeline. Consumes the ID-stage
//   source-usage flags (R1_Used/R2_Used) and register numbers, tracks in-flight destinations
//   of EX/MEM/WB in an internal 3-entry shift scoreboard, and issues load-use stalls plus
//   registered forwarding selects for the EX stage. Sits beside the controller between ID and EX.
// PARAMETERS
//   REG_AW  5   register-number width
//   CNT_W   16  width of saturating stall-cycle counter
// PORTS
//   clk          in   1       pipeline clock, all state on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   id_valid     in   1       ID stage holds a real instruction
//   id_rs1       in   REG_AW  ID source 1 number
//   id_rs2       in   REG_AW  ID source 2 number
//   r1_used      in   1       ID instruction reads rs1 (from register_used)
//   r2_used      in   1       ID instruction reads rs2 (from register_used)
//   id_rd        in   REG_AW  ID destination number
//   id_reg_write in   1       ID instruction writes id_rd
//   id_mem_read  in   1       ID instruction is a load (lb/lh/lw/lbu/lhu)
//   flush        in   1       redirect (taken branch/jump, interrupt entry, uret): kill ID instr
//   stall        out  1       hold PC and IF/ID, bubble into EX (combinational)
//   fwd_a        out  2       EX operand A select, registered: 00 RF, 01 MEM, 10 WB
//   fwd_b        out  2       EX operand B select, same encoding
//   stall_cnt    out  CNT_W   number of stall cycles since reset, saturating
// BEHAVIOUR
//   - Entry = {v, rd, wen, ld}; wen forced 0 when rd==0. Stages EX, MEM, WB.
//   - Reset (async, rst_n=0): all entries v=0, fwd_a=fwd_b=00, stall_cnt=0; stall reads 0.
//   - hit(rs,used,E) = used & id_valid & E.v & E.wen & (rs==E.rd) & (rs!=0).
//   - stall = ~flush & (hit(rs1,r1_used,EX)|hit(rs2,r2_used,EX)) & EX.ld. Only load-use stalls;
//     exactly one bubble per load-use pair (load moves to MEM, then forwarding from WB covers it).
//   - Each edge: WB<=MEM, MEM<=EX unconditionally.
//     EX<=ID entry if id_valid & ~stall & ~flush; else EX<=bubble (v=0).
//   - Forward select computed in ID against the entries that will be one stage older when the
//     instr reaches EX: EX hit -> 01 (priority, youngest), else MEM hit -> 10, else 00.
//     Registered into fwd_a/fwd_b on the same edge the instr enters EX; bubble -> 00.
//     Latency: select valid exactly the cycle the instruction occupies EX.
//   - Current-WB entry is never a forward source: register file writes first half / bypasses.
//   - flush has priority over stall: stall=0, EX<=bubble, stall_cnt not incremented.
//   - stall_cnt += 1 each cycle stall=1; holds at 2^CNT_W-1, no wrap.
//   - Reset mid-stall: scoreboard cleared, stall drops in the same cycle rst_n falls.
//   - Both sources equal same rd: both selects identical; r*_used=0 sources never stall/forward.
// STRUCTURE
//   - Shared package hazard_pkg: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; scoreboard
//     entry struct/field widths; REG_AW default.
//   - One sub-module fwd_select (pure compare: rs, used, EX entry, MEM entry -> 2-bit select,
//     load-hit flag), instantiated for rs1 and rs2. Top holds shift entries, stall, counter.
// TESTING
//   - Reset: rst_n=0 with id traffic -> stall=0, fwd=00, stall_cnt=0; release, entries empty.
//   - ADD x5 then ADD x6,x5,x5 -> no stall; 2nd instr in EX sees fwd_a=fwd_b=01.
//   - LW x5 then ADD x6,x5,x0 -> stall=1 one cycle, stall_cnt=1, next cycle fwd_a=10, fwd_b=00.
//   - ADD x5; NOP; SW x5,0(x5) -> fwd_a=fwd_b=10; ADDI x0 then use x0 -> fwd 00, no stall.
//   - LW x7 then BEQ x7,x1 with flush=1 in the hazard cycle -> stall=0, EX bubble, cnt unchanged.
//   - CNT_W=2: force 5 load-use stalls -> stall_cnt saturates at 3; async rst_n mid-stall clears.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and entry layout for the ID/EX operand hazard scoreboard.
// No logic here: forward-select encoding, default register-number width, entry layout.
// Imported by the scoreboard top and by the per-source forward selector.
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // One in-flight destination: valid, register number, writes-register, is-a-load.
  typedef struct packed {
    logic                      v;
    logic [REG_AW_DEFAULT-1:0] rd;
    logic                      wen;
    logic                      ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Per-source compare of one ID operand against the EX and MEM scoreboard entries.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the select is registered or a stall raised.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              used,
  input  logic              id_valid,
  input  logic              ex_v,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_ld,
  input  logic              mem_v,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  output logic [1:0]        sel,
  output logic              load_hit
);

  logic src_ok;
  logic ex_hit;
  logic mem_hit;

  // Youngest producer wins: the EX occupant will sit in MEM when this operand reaches EX.
  always_comb begin
    src_ok   = used & id_valid & (rs != '0);
    ex_hit   = src_ok & ex_v & ex_wen & (rs == ex_rd);
    mem_hit  = src_ok & mem_v & mem_wen & (rs == mem_rd);
    load_hit = ex_hit & ex_ld;
    sel      = FWD_RF;
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand hazard scoreboard between ID and EX: load-use stall plus registered EX forward selects.
// Latency: stall is combinational in the ID cycle; fwd_a/fwd_b are valid the cycle the instr is in EX.
// Backpressure: stall holds PC and IF/ID and bubbles EX; flush overrides stall and kills the ID instr.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              r1_used,
  input  logic              r2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The WB slot is never a forward source (register file writes through), so only the
  // EX and MEM destinations are kept; a MEM entry simply drains after one more edge.
  logic              ex_v_q, ex_v_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_wen_q, ex_wen_d;
  logic              ex_ld_q, ex_ld_d;
  logic              mem_v_q, mem_v_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_wen_q, mem_wen_d;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0] sel_a, sel_b;
  logic       load_hit_a, load_hit_b;
  logic       issue;

  fwd_select #(.REG_AW(REG_AW)) u_sel_a (
    .rs       (id_rs1),
    .used     (r1_used),
    .id_valid (id_valid),
    .ex_v     (ex_v_q),
    .ex_rd    (ex_rd_q),
    .ex_wen   (ex_wen_q),
    .ex_ld    (ex_ld_q),
    .mem_v    (mem_v_q),
    .mem_rd   (mem_rd_q),
    .mem_wen  (mem_wen_q),
    .sel      (sel_a),
    .load_hit (load_hit_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_sel_b (
    .rs       (id_rs2),
    .used     (r2_used),
    .id_valid (id_valid),
    .ex_v     (ex_v_q),
    .ex_rd    (ex_rd_q),
    .ex_wen   (ex_wen_q),
    .ex_ld    (ex_ld_q),
    .mem_v    (mem_v_q),
    .mem_rd   (mem_rd_q),
    .mem_wen  (mem_wen_q),
    .sel      (sel_b),
    .load_hit (load_hit_b)
  );

  // Next-state: shift EX into MEM, admit the ID instr unless stalled or flushed, count stalls.
  always_comb begin
    stall     = ~flush & (load_hit_a | load_hit_b);
    issue     = id_valid & ~stall & ~flush;
    mem_v_d   = ex_v_q;
    mem_rd_d  = ex_rd_q;
    mem_wen_d = ex_wen_q;
    ex_v_d    = issue;
    ex_rd_d   = id_rd;
    ex_wen_d  = id_reg_write & (id_rd != '0);
    ex_ld_d   = id_mem_read;
    fwd_a_d   = issue ? sel_a : FWD_RF;
    fwd_b_d   = issue ? sel_b : FWD_RF;
    cnt_d     = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Scoreboard, forward-select and counter registers; reset empties the pipeline immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q    <= 1'b0;
      ex_rd_q   <= '0;
      ex_wen_q  <= 1'b0;
      ex_ld_q   <= 1'b0;
      mem_v_q   <= 1'b0;
      mem_rd_q  <= '0;
      mem_wen_q <= 1'b0;
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      cnt_q     <= '0;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_rd_q   <= ex_rd_d;
      ex_wen_q  <= ex_wen_d;
      ex_ld_q   <= ex_ld_d;
      mem_v_q   <= mem_v_d;
      mem_rd_q  <= mem_rd_d;
      mem_wen_q <= mem_wen_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized traffic against a model.
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
// The model tracks issued instructions by the cycle they entered EX and derives hazards by age.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        r1_used = 1'b0, r2_used = 1'b0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic        stall, stall_s;
  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_s;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .r1_used(r1_used), .r2_used(r2_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.REG_AW(5), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .r1_used(r1_used), .r2_used(r2_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .stall(stall_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
    .stall_cnt(stall_cnt_s)
  );

  typedef struct {
    int         cyc;
    logic [4:0] rd;
    bit         wr;
    bit         ld;
  } rec_t;

  rec_t        issued[$];
  int          cyc = 0;
  int          exp_cnt = 0;
  bit          exp_stall = 0;
  logic [1:0]  exp_fa = 2'b00, exp_fb = 2'b00;
  logic        obs_stall, obs_stall_s;
  logic [1:0]  obs_fa, obs_fb, obs_fa_s, obs_fb_s, obs_cnt_s;
  logic [15:0] obs_cnt;
  int          errors = 0;
  int          checks = 0;

  task automatic model_reset();
    issued.delete();
    exp_cnt   = 0;
    exp_stall = 0;
    exp_fa    = 2'b00;
    exp_fb    = 2'b00;
  endtask

  // Find the youngest writer of rs among instructions that entered EX one or two edges ago.
  function automatic void src_lookup(input logic [4:0] rs, input bit used,
                                     output logic [1:0] sel, output bit ld_use);
    bit in_ex = 0, in_mem = 0, ex_ld = 0;
    sel    = 2'b00;
    ld_use = 0;
    if (!used || !id_valid || rs == 5'd0) return;
    foreach (issued[i]) begin
      if (issued[i].wr && issued[i].rd == rs) begin
        if (issued[i].cyc == cyc) begin
          in_ex = 1;
          ex_ld = issued[i].ld;
        end else if (issued[i].cyc == cyc - 1) begin
          in_mem = 1;
        end
      end
    end
    if (in_ex) begin
      sel    = 2'b01;
      ld_use = ex_ld;
    end else if (in_mem) begin
      sel = 2'b10;
    end
  endfunction

  // One clock: sample combinational stall mid-cycle, advance model, sample registered outputs.
  task automatic tick();
    logic [1:0] s1, s2;
    bit l1, l2, issue;
    @(negedge clk);
    obs_stall   = stall;
    obs_stall_s = stall_s;
    src_lookup(id_rs1, r1_used, s1, l1);
    src_lookup(id_rs2, r2_used, s2, l2);
    exp_stall = !flush && (l1 || l2);
    issue     = id_valid && !exp_stall && !flush;
    @(posedge clk);
    cyc++;
    if (issue) begin
      rec_t r;
      r.cyc = cyc; r.rd = id_rd; r.wr = id_reg_write; r.ld = id_mem_read;
      issued.push_back(r);
    end
    while (issued.size() > 0 && issued[0].cyc < cyc - 2) void'(issued.pop_front());
    exp_fa = issue ? s1 : 2'b00;
    exp_fb = issue ? s2 : 2'b00;
    if (exp_stall && exp_cnt < 65535) exp_cnt++;
    #1;
    obs_fa    = fwd_a;
    obs_fb    = fwd_b;
    obs_fa_s  = fwd_a_s;
    obs_fb_s  = fwd_b_s;
    obs_cnt   = stall_cnt;
    obs_cnt_s = stall_cnt_s;
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input logic [4:0] rd,
                        input bit we, input bit ld, input bit fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; r1_used = u1; r2_used = u2;
    id_rd = rd; id_reg_write = we; id_mem_read = ld; flush = fl;
  endtask

  task automatic nop();
    set_id(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1, rs1, rs2, 1, 1, rd, 1, 0, 0);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] base);
    set_id(1, base, 5'd0, 1, 0, rd, 1, 1, 0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    lw(5, 1);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd got=%b/%b want=00/00", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, stall_cnt_s); end
    @(posedge clk); #1;
    add(6, 5, 5);
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0 || fwd_a !== 2'b00 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_hold got stall=%b fwd_a=%b cnt=%0d want 0/00/0", stall, fwd_a, stall_cnt);
    end
    rst_n = 1'b1;
    model_reset();
    add(6, 5, 5);
    tick();
    checks++; if (obs_stall !== 1'b0 || obs_fa !== 2'b00 || obs_fb !== 2'b00) begin
      errors++; $display("FAIL reset_empty got stall=%b fwd=%b/%b want 0/00/00", obs_stall, obs_fa, obs_fb);
    end
    drain();
  endtask

  task automatic test_fwd_ex();
    add(5, 1, 2);
    tick();
    add(6, 5, 5);
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall got=%b want=0", obs_stall); end
    checks++; if (obs_fa !== 2'b01 || obs_fb !== 2'b01) begin errors++; $display("FAIL fwd_ex_sel got=%b/%b want=01/01", obs_fa, obs_fb); end
    drain();
  endtask

  task automatic test_load_use();
    lw(5, 1);
    tick();
    set_id(1, 5, 0, 1, 1, 6, 1, 0, 0);
    tick();
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b want=1", obs_stall); end
    checks++; if (obs_cnt !== 16'd1 || obs_cnt_s !== 2'd1) begin errors++; $display("FAIL lu_cnt got=%0d/%0d want=1/1", obs_cnt, obs_cnt_s); end
    checks++; if (obs_fa !== 2'b00) begin errors++; $display("FAIL lu_bubble got=%b want=00", obs_fa); end
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b want=0", obs_stall); end
    checks++; if (obs_fa !== 2'b10 || obs_fb !== 2'b00) begin errors++; $display("FAIL lu_fwd got=%b/%b want=10/00", obs_fa, obs_fb); end
    checks++; if (obs_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold got=%0d want=1", obs_cnt); end
    drain();
  endtask

  task automatic test_wb_and_x0();
    add(5, 1, 2);
    tick();
    nop();
    tick();
    set_id(1, 5, 5, 1, 1, 0, 0, 0, 0);
    tick();
    checks++; if (obs_fa !== 2'b10 || obs_fb !== 2'b10 || obs_stall !== 1'b0) begin
      errors++; $display("FAIL fwd_wb got=%b/%b stall=%b want=10/10 0", obs_fa, obs_fb, obs_stall);
    end
    set_id(1, 1, 0, 1, 0, 0, 1, 0, 0);
    tick();
    add(1, 0, 0);
    tick();
    checks++; if (obs_fa !== 2'b00 || obs_fb !== 2'b00 || obs_stall !== 1'b0) begin
      errors++; $display("FAIL x0_add got=%b/%b stall=%b want=00/00 0", obs_fa, obs_fb, obs_stall);
    end
    lw(0, 1);
    tick();
    add(2, 0, 0);
    tick();
    checks++; if (obs_stall !== 1'b0 || obs_fa !== 2'b00) begin errors++; $display("FAIL x0_load got stall=%b fwd=%b want 0/00", obs_stall, obs_fa); end
    lw(9, 1);
    tick();
    set_id(1, 9, 9, 0, 0, 3, 1, 0, 0);
    tick();
    checks++; if (obs_stall !== 1'b0 || obs_fa !== 2'b00 || obs_fb !== 2'b00) begin
      errors++; $display("FAIL unused_src got stall=%b fwd=%b/%b want 0/00/00", obs_stall, obs_fa, obs_fb);
    end
    drain();
  endtask

  task automatic test_flush();
    lw(7, 1);
    tick();
    set_id(1, 7, 1, 1, 1, 0, 0, 0, 1);
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", obs_stall); end
    checks++; if (obs_fa !== 2'b00 || obs_fb !== 2'b00) begin errors++; $display("FAIL flush_bubble got=%b/%b want=00/00", obs_fa, obs_fb); end
    checks++; if (obs_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got=%0d want=1", obs_cnt); end
    add(8, 7, 7);
    tick();
    checks++; if (obs_stall !== 1'b0 || obs_fa !== 2'b10 || obs_fb !== 2'b10) begin
      errors++; $display("FAIL flush_after got stall=%b fwd=%b/%b want 0/10/10", obs_stall, obs_fa, obs_fb);
    end
    drain();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 5; k++) begin
      lw(5, 1);
      tick();
      add(6, 5, 5);
      tick();
      checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL sat_stall%0d got=%b want=1", k, obs_stall); end
      tick();
    end
    checks++; if (obs_cnt_s !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got=%0d want=3", obs_cnt_s); end
    checks++; if (obs_cnt !== 16'd6) begin errors++; $display("FAIL sat_cnt16 got=%0d want=6", obs_cnt); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    lw(5, 1);
    tick();
    add(6, 5, 5);
    @(negedge clk);
    checks++; if (stall !== 1'b1 || stall_s !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b/%b want=1/1", stall, stall_s); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || stall_s !== 1'b0) begin errors++; $display("FAIL mid_stall got=%b/%b want=0/0", stall, stall_s); end
    checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 2'd0) begin errors++; $display("FAIL mid_cnt got=%0d/%0d want=0/0", stall_cnt, stall_cnt_s); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    nop();
    tick();
    checks++; if (obs_fa !== 2'b00 || obs_cnt !== 16'd0) begin errors++; $display("FAIL mid_after got fwd=%b cnt=%0d want 00/0", obs_fa, obs_cnt); end
    drain();
  endtask

  task automatic test_random();
    int sat;
    for (int n = 0; n < 600; n++) begin
      if (!exp_stall) begin
        set_id(1'($urandom_range(9, 0) != 0), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 5'($urandom_range(3, 0)),
               1'($urandom_range(9, 0) < 7), 1'($urandom_range(9, 0) < 4), 0);
      end
      flush = ($urandom_range(9, 0) == 0);
      tick();
      sat = (exp_cnt > 3) ? 3 : exp_cnt;
      checks++; if (obs_stall !== exp_stall || obs_stall_s !== exp_stall) begin
        errors++; $display("FAIL rnd_stall n=%0d got=%b/%b want=%b", n, obs_stall, obs_stall_s, exp_stall);
      end
      checks++; if (obs_fa !== exp_fa || obs_fb !== exp_fb) begin
        errors++; $display("FAIL rnd_fwd n=%0d got=%b/%b want=%b/%b", n, obs_fa, obs_fb, exp_fa, exp_fb);
      end
      checks++; if (obs_fa_s !== exp_fa || obs_fb_s !== exp_fb) begin
        errors++; $display("FAIL rnd_fwd_s n=%0d got=%b/%b want=%b/%b", n, obs_fa_s, obs_fb_s, exp_fa, exp_fb);
      end
      checks++; if (obs_cnt !== 16'(exp_cnt) || obs_cnt_s !== 2'(sat)) begin
        errors++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, obs_cnt, obs_cnt_s, exp_cnt, sat);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_wb_and_x0();
    test_flush();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
